// File: rtl/pb_uart_tx.sv
// pb_uart_tx - push-button triggered UART transmitter (8 data bits, 1 or 2 stop bits).
//
// A one-cycle trigger captures data_in and sends it as one frame on tx:
// a start bit, 8 data bits LSB first, then the stop bit(s). A trigger that
// arrives while a frame is in flight is held in a one-deep pending slot and
// sent right after the current frame. A trigger that arrives when the slot is
// already full is dropped and flagged on overrun.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   trig     in   one-cycle send request (already synchronous to clk)
//   data_in  in   byte to send, sampled only on an accepted trig
//   tx       out  serial line, idle high
//   busy     out  high from the first start-bit cycle through the last stop-bit cycle
//   done     out  one-cycle pulse in the cycle after the last stop-bit cycle
//   overrun  out  one-cycle pulse when a trigger is dropped
//
// All outputs come straight from flops; there is no input-to-output path.

module pb_uart_tx #(
  parameter int CLKS_PER_BIT = 2500,  // clk cycles per bit, 2..4095
  parameter int CNT_W        = 12,    // 2**CNT_W must exceed CLKS_PER_BIT
  parameter int STOP_BITS    = 1      // 1 or 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;        // cycle within the current bit, 0..CLKS_PER_BIT-1
  logic [2:0]       idx_q;        // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shreg_q;      // bit 0 is always the bit currently on the line
  logic [7:0]       pend_data_q;
  logic             pending_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      pend_data_q <= '0;
      pending_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (pending_q) begin
            // The held byte goes first; a same-cycle trigger refills the slot.
            shreg_q   <= pend_data_q;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            pending_q <= trig;
            if (trig) begin
              pend_data_q <= data_in;
            end
          end else if (trig) begin
            shreg_q <= data_in;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q >> 1;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shreg_q[1];  // next bit, before the shift lands
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == STOP_LAST) begin
              idx_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

      // Triggers while a frame is in flight fill the slot or are dropped.
      if (state_q != IDLE && trig) begin
        if (!pending_q) begin
          pending_q   <= 1'b1;
          pend_data_q <= data_in;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pb_uart_tx.sv
// Testbench for pb_uart_tx. Two instances: A (4 clocks/bit, 1 stop bit) and
// B (3 clocks/bit, 2 stop bits). Each scenario is a table of trigger cycles;
// expected line behaviour comes from a frame-level model (frame start cycle,
// bit = (cycle - start) / CLKS_PER_BIT, one pending slot).

module tb_pb_uart_tx;

  localparam int C_A  = 4;
  localparam int SB_A = 1;
  localparam int C_B  = 3;
  localparam int SB_B = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       trig_a, trig_b;
  logic [7:0] data_a, data_b;
  logic       tx_a, busy_a, done_a, ovr_a;
  logic       tx_b, busy_b, done_b, ovr_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Trigger schedule: cycle -> byte
  logic [7:0] sched [int];
  int         done_cycles [$];
  int         ovr_cycles  [$];

  // Frame-level model state
  logic       m_valid;
  int         m_s;
  logic [7:0] m_data;
  logic       p_valid;
  logic [7:0] p_data;

  always #5 clk = ~clk;

  pb_uart_tx #(.CLKS_PER_BIT(C_A), .CNT_W(12), .STOP_BITS(SB_A)) u_dut_a (
    .clk(clk), .reset(reset), .trig(trig_a), .data_in(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  pb_uart_tx #(.CLKS_PER_BIT(C_B), .CNT_W(12), .STOP_BITS(SB_B)) u_dut_b (
    .clk(clk), .reset(reset), .trig(trig_b), .data_in(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  task automatic do_reset();
    @(negedge clk);
    trig_a = 1'b0; trig_b = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Edge c samples trig; outputs are checked in cycle c+1 (#1 after edge c).
  task automatic run_scenario(input int sel, input int ncycles, input string name);
    int         cb, len, n, k;
    logic       t, idle;
    logic [7:0] d;
    logic       e_tx, e_busy, e_done, e_ovr;
    logic       o_tx, o_busy, o_done, o_ovr;
    cb  = (sel != 0) ? C_B : C_A;
    len = (9 + ((sel != 0) ? SB_B : SB_A)) * cb;
    m_valid = 1'b0; m_s = 0; m_data = '0;
    p_valid = 1'b0; p_data = '0;
    done_cycles.delete();
    ovr_cycles.delete();
    @(negedge clk);
    for (int c = 0; c < ncycles; c++) begin
      t = sched.exists(c);
      d = t ? sched[c] : 8'($urandom);
      if (sel != 0) begin trig_b = t; data_b = d; end
      else          begin trig_a = t; data_a = d; end

      // model: what edge c does
      idle  = !(m_valid && c >= m_s && c <= m_s + len - 1);
      e_ovr = 1'b0;
      if (idle) begin
        if (p_valid) begin
          m_valid = 1'b1; m_s = c + 1; m_data = p_data;
          p_valid = t;
          if (t) p_data = d;
        end else if (t) begin
          m_valid = 1'b1; m_s = c + 1; m_data = d;
        end
      end else if (t) begin
        if (!p_valid) begin p_valid = 1'b1; p_data = d; end
        else e_ovr = 1'b1;
      end
      n      = c + 1;
      e_busy = m_valid && n >= m_s && n <= m_s + len - 1;
      e_done = m_valid && (n == m_s + len);
      e_tx   = 1'b1;
      if (e_busy) begin
        k = (n - m_s) / cb;
        if (k == 0)      e_tx = 1'b0;
        else if (k <= 8) e_tx = m_data[k-1];
      end

      @(posedge clk);
      #1;
      o_tx   = (sel != 0) ? tx_b   : tx_a;
      o_busy = (sel != 0) ? busy_b : busy_a;
      o_done = (sel != 0) ? done_b : done_a;
      o_ovr  = (sel != 0) ? ovr_b  : ovr_a;

      tests_run++;
      if (o_tx !== e_tx) begin
        tests_failed++;
        $display("FAIL %s_tx cycle %0d: got %b expected %b", name, n, o_tx, e_tx);
      end
      tests_run++;
      if (o_busy !== e_busy) begin
        tests_failed++;
        $display("FAIL %s_busy cycle %0d: got %b expected %b", name, n, o_busy, e_busy);
      end
      tests_run++;
      if (o_done !== e_done) begin
        tests_failed++;
        $display("FAIL %s_done cycle %0d: got %b expected %b", name, n, o_done, e_done);
      end
      tests_run++;
      if (o_ovr !== e_ovr) begin
        tests_failed++;
        $display("FAIL %s_overrun cycle %0d: got %b expected %b", name, n, o_ovr, e_ovr);
      end
      if (o_done === 1'b1) begin
        done_cycles.push_back(n);
        $display("[TB] %s: frame done at cycle %0d", name, n);
      end
      if (o_ovr === 1'b1) begin
        ovr_cycles.push_back(n);
        $display("[TB] %s: trigger dropped at cycle %0d", name, n);
      end
      @(negedge clk);
    end
    trig_a = 1'b0; trig_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; trig_a = 1'b0; trig_b = 1'b0; data_a = 8'hFF; data_b = 8'hFF;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx_a, busy_a, done_a, ovr_a} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_a: got tx/busy/done/ovr %b expected 1000", {tx_a, busy_a, done_a, ovr_a});
    end
    tests_run++;
    if ({tx_b, busy_b, done_b, ovr_b} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_b: got tx/busy/done/ovr %b expected 1000", {tx_b, busy_b, done_b, ovr_b});
    end
    reset = 1'b1;
  endtask

  task automatic test_single_frame();
    int got;
    do_reset();
    sched.delete(); sched[0] = 8'hA5;
    run_scenario(0, 60, "single");
    got = (done_cycles.size() > 0) ? done_cycles[0] : -1;
    tests_run++;
    if (done_cycles.size() != 1 || got != 41) begin
      tests_failed++;
      $display("FAIL single_done_cycle: got %0d (count %0d) expected 41 (count 1)", got, done_cycles.size());
    end
  endtask

  task automatic test_back_to_back();
    int g0, g1;
    do_reset();
    sched.delete(); sched[0] = 8'h3C; sched[10] = 8'hC3;
    run_scenario(0, 100, "b2b");
    g0 = (done_cycles.size() > 0) ? done_cycles[0] : -1;
    g1 = (done_cycles.size() > 1) ? done_cycles[1] : -1;
    tests_run++;
    if (g0 != 41 || g1 != 82) begin
      tests_failed++;
      $display("FAIL b2b_done_cycles: got %0d,%0d expected 41,82", g0, g1);
    end
  endtask

  task automatic test_overrun();
    int g;
    do_reset();
    sched.delete(); sched[0] = 8'h11; sched[5] = 8'h22; sched[9] = 8'h33;
    run_scenario(0, 120, "overrun");
    g = (ovr_cycles.size() > 0) ? ovr_cycles[0] : -1;
    tests_run++;
    if (ovr_cycles.size() != 1 || g != 10) begin
      tests_failed++;
      $display("FAIL overrun_cycle: got %0d (count %0d) expected 10 (count 1)", g, ovr_cycles.size());
    end
    tests_run++;
    if (done_cycles.size() != 2) begin
      tests_failed++;
      $display("FAIL overrun_frames: got %0d frames expected 2", done_cycles.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    sched.delete(); sched[0] = 8'hFF; sched[5] = 8'h42;
    run_scenario(0, 17, "mid_reset");
    tests_run++;
    if (busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_busy_before: got %b expected 1", busy_a);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({tx_a, busy_a, done_a, ovr_a} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got tx/busy/done/ovr %b expected 1000", {tx_a, busy_a, done_a, ovr_a});
    end
    @(negedge clk);
    reset = 1'b1;
    sched.delete();
    run_scenario(0, 100, "post_reset");
    tests_run++;
    if (done_cycles.size() != 0) begin
      tests_failed++;
      $display("FAIL post_reset_frames: got %0d done pulses expected 0", done_cycles.size());
    end
  endtask

  task automatic test_two_stop_bits();
    int g;
    do_reset();
    sched.delete(); sched[0] = 8'h00;
    run_scenario(1, 50, "stop2");
    g = (done_cycles.size() > 0) ? done_cycles[0] : -1;
    tests_run++;
    if (g != 34) begin
      tests_failed++;
      $display("FAIL stop2_done_cycle: got %0d expected 34", g);
    end
  endtask

  task automatic test_collision();
    int g2;
    do_reset();
    sched.delete(); sched[0] = 8'h11; sched[5] = 8'h22; sched[41] = 8'h5A;
    run_scenario(0, 170, "collision");
    g2 = (done_cycles.size() > 2) ? done_cycles[2] : -1;
    tests_run++;
    if (done_cycles.size() != 3 || g2 != 123 || ovr_cycles.size() != 0) begin
      tests_failed++;
      $display("FAIL collision_frames: got %0d frames, third done %0d, %0d overruns expected 3, 123, 0",
               done_cycles.size(), g2, ovr_cycles.size());
    end
  endtask

  task automatic test_random();
    int dens [4] = '{2, 5, 10, 30};
    for (int r = 0; r < 4; r++) begin
      do_reset();
      sched.delete();
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 99) < dens[r]) sched[c] = 8'($urandom);
      end
      run_scenario(r % 2, 600, "random");
    end
  endtask

  initial begin
    trig_a = 1'b0; trig_b = 1'b0; data_a = '0; data_b = '0; reset = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_two_stop_bits();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
